booth_multiplier_seq: RTL and testbench
=======================================

# booth_multiplier_seq

Sequential signed 32×32 multiplier built on radix-2 Booth recoding. It produces an exact 64-bit two's-complement product split into `hi` and `lo` words for the HI/LO register pair. It is the multiply-side counterpart of the ALU's signed divider. It sits beside the divider in the ALU and is driven by the control unit through a start/done handshake.

## Interface
- `WIDTH`, default 32: operand width. Product width is 2×WIDTH. Only 32 is required to be verified.
- `clk` in 1: the only clock. Rising-edge triggered.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: request pulse. Sampled only in IDLE.
- `multiplicand` in 32: signed operand M. Sampled on the accepting edge.
- `multiplier` in 32: signed operand Q. Sampled on the accepting edge.
- `busy` out 1: high while an operation is in flight (RUN state).
- `done` out 1: single-cycle completion strobe.
- `hi` out 32: product bits [63:32].
- `lo` out 32: product bits [31:0].

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1 for exactly one cycle.
- Transitions:
  - IDLE→RUN on `start`=1.
  - RUN→DONE after the 32nd Booth step.
  - DONE→IDLE unconditionally.
- Accept edge:
  - latch M := `multiplicand` into an internal 33-bit sign-extended register.
  - A := 33'b0.
  - Q := `multiplier`.
  - q₋₁ := 0.
  - step counter := 0.
- Booth step (one per RUN edge), selected by {Q[0], q₋₁}:
  - 10: A := A − M.
  - 01: A := A + M.
  - 00 / 11: A unchanged.
  - Then arithmetic right shift of the 66-bit {A, Q, q₋₁} by 1, replicating A[32].
- Arithmetic width:
  - A and M are 33 bits, so M = −2³¹ (0x80000000) negates without overflow.
  - The 64-bit result is exact for every input pair, including 0x80000000 × 0x80000000.
- Completion: on the edge that performs step 32, load `hi` := A[31:0] and `lo` := Q, and enter DONE.
- Output holding:
  - `hi`/`lo` change only on a completion edge or on `clr`.
  - Between operations they hold the last result.
  - They are not valid mid-operation for the new operands; they still show the previous result.
- `start` in RUN or DONE is ignored and not queued. Operand changes while busy have no effect.
- `start` held high continuously launches a new operation from each IDLE cycle (a back-to-back period of 34 cycles).
- Reset (`clr`=1 at any edge, including mid-RUN):
  - state := IDLE.
  - `busy`=0, `done`=0.
  - `hi`=0, `lo`=0.
  - internal A, Q, M, q₋₁ and counter := 0.
  - The in-flight operation is discarded with no `done` pulse.
- `clr` and `start` at the same edge: `clr` wins and `start` is dropped.

## Timing
- Edge E0: `start` is sampled high in IDLE, and `busy` rises after E0.
- Edges E1–E32: the 32 Booth steps are performed.
- E32 completion:
  - `hi`/`lo` are updated.
  - `busy` falls.
  - `done` is high during the cycle between E32 and E33.
- E33: the block returns to IDLE, and a new `start` can be accepted at E34 at the earliest.
- Latency: 32 cycles from the accepting edge to valid outputs and `done`. Throughput is one operation per 34 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- 7 × 3: start once → `done` exactly 32 cycles after the accept edge, `hi`=0x00000000, `lo`=0x00000015; `busy` high for 32 cycles.
- −7 × 3 (0xFFFFFFF9, 0x00000003) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then −7 × −3 → `hi`=0, `lo`=0x15.
- Corner operands:
  - 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
  - 0x80000000 × 0x00000001 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
  - 0x7FFFFFFF × 0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001.
- `start` pulsed with new operands (5, 5) at cycle 10 of an in-flight 6 × 4 → a single `done` with `lo`=0x18. No second operation starts. `hi`/`lo` keep the old value until the completion edge.
- `clr` asserted at cycle 15 of RUN → the next cycle shows `busy`=0, `done`=0, `hi`=`lo`=0, and no `done` ever fires for that operation. A subsequent 2 × 9 completes normally with `lo`=0x12.
- `start` held high for 100 cycles with 1 × 1 → `done` pulses every 34 cycles. Each pulse lasts exactly one cycle with `lo`=1.

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Sequential signed WIDTH x WIDTH multiplier using radix-2 Booth recoding.
// It performs one Booth step per clock and produces the exact 2*WIDTH-bit
// two's-complement product, split into hi/lo words for the HI/LO pair.
//
// Handshake (valid/ready): start acts as "valid" and the IDLE state acts as
// "ready". An operation is accepted only on an edge where start=1 and the
// FSM is in IDLE. start in RUN or DONE is dropped and is not queued.
// done is a one-cycle completion strobe. hi/lo are valid while done=1 and
// hold that result until the next completion edge or clr.
//
// Ports:
//   clk          - clock, rising edge
//   clr          - synchronous active-high reset
//   start        - request pulse, sampled only in IDLE
//   multiplicand - signed operand M, latched on the accepting edge
//   multiplier   - signed operand Q, latched on the accepting edge
//   busy         - high while in RUN
//   done         - high for the single cycle spent in DONE
//   hi           - product bits [2*WIDTH-1:WIDTH]
//   lo           - product bits [WIDTH-1:0]
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The state register is kept as a named internal signal so that checkers
  // can be bound to it.
  state_t state;
  state_t state_next;

  // A and M carry one extra bit, so negating M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic             last_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH-1:0] q_shift;

  assign last_step = (cnt == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Both outputs decode the state register directly, so they stay registered.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Booth add/subtract selected by the current multiplier LSB pair
  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b10:   sum = a - m;
      2'b01:   sum = a + m;
      default: sum = a;
    endcase
  end

  // Arithmetic right shift of {A, Q, q_m1}. A's sign bit is replicated, and
  // A's LSB moves into Q's MSB.
  assign a_shift = {sum[WIDTH], sum[WIDTH:1]};
  assign q_shift = {sum[0], q[WIDTH-1:1]};

  // Datapath
  always_ff @(posedge clk) begin
    if (clr) begin
      a    <= '0;
      m    <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m    <= {multiplicand[WIDTH-1], multiplicand};
            a    <= '0;
            q    <= multiplier;
            q_m1 <= 1'b0;
            cnt  <= '0;
          end
        end
        ST_RUN: begin
          a    <= a_shift;
          q    <= q_shift;
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          // The final step writes straight into the result registers, so
          // hi/lo keep the previous product until this edge.
          if (last_step) begin
            hi <= a_shift[WIDTH-1:0];
            lo <= q_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Testbench for booth_multiplier_seq (WIDTH = 32).
module tb_booth_multiplier_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic        done_prev = 1'b0;

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: each done pulse pops one expected product.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", {63'b0, done_prev}, 64'd0);
      check("done_expected", {63'b0, (exp_q.size() != 0)}, 64'd1);
      if (exp_q.size() != 0) check("product", {hi, lo}, exp_q.pop_front());
    end
    done_prev = done;
  end

  // Driver: one operation with latency and busy-length checks.
  // Operands are scrambled mid-run to show that they are ignored.
  task automatic run_op(input string tag, input logic [31:0] mm, input logic [31:0] qq,
                        input logic [63:0] expv);
    int done_at;
    int busy_cnt;
    @(negedge clk);
    multiplicand = mm;
    multiplier   = qq;
    start        = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start    = 1'b0;
    done_at  = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = k;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(done_at), 64'd32);
    check({tag, "_busy_len"}, 64'(busy_cnt), 64'd32);
  endtask

  initial begin
    int dcount;
    int done_at;
    int hold_bad;
    int dpos[$];
    logic [31:0] ra;
    logic [31:0] rb;
    longint p;

    clr          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    clr = 1'b0;

    run_op("7x3",   32'd7,          32'd3,          64'h00000000_00000015);
    run_op("m7x3",  32'hFFFFFFF9,   32'h00000003,   64'hFFFFFFFF_FFFFFFEB);
    run_op("m7xm3", 32'hFFFFFFF9,   32'hFFFFFFFD,   64'h00000000_00000015);

    // A start during RUN is ignored. hi/lo keep 0x15 until the completion edge.
    @(negedge clk);
    multiplicand = 32'd6;
    multiplier   = 32'd4;
    start        = 1'b1;
    exp_q.push_back(64'h18);
    @(negedge clk);
    start    = 1'b0;
    dcount   = 0;
    done_at  = -1;
    hold_bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (k == 10) begin
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        start        = 1'b1;
      end
      if (k == 11) start = 1'b0;
      if (k < 32 && {hi, lo} !== 64'h15) hold_bad++;
      if (done) begin
        dcount++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    check("ignore_start_dones", 64'(dcount), 64'd1);
    check("ignore_start_latency", 64'(done_at), 64'd32);
    check("hold_old_result", 64'(hold_bad), 64'd0);

    run_op("minxmin", 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("minx1",   32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
    run_op("maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 65535) - 32768;
      p  = longint'($signed(ra)) * longint'($signed(rb));
      run_op("random", ra, rb, 64'(p));
    end

    // clr mid-run discards the operation.
    @(negedge clk);
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    start        = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 15) clr = 1'b1;
      if (k == 16) begin
        check("clr_busy", {63'b0, busy}, 64'd0);
        check("clr_done", {63'b0, done}, 64'd0);
        check("clr_hilo", {hi, lo}, 64'd0);
        clr = 1'b0;
      end
      if (done) dcount++;
      @(negedge clk);
    end
    check("clr_no_done", 64'(dcount), 64'd0);
    run_op("2x9", 32'd2, 32'd9, 64'h12);

    // With start held high, operations are accepted at E0, E34 and E68.
    @(negedge clk);
    multiplicand = 32'd1;
    multiplier   = 32'd1;
    start        = 1'b1;
    repeat (3) exp_q.push_back(64'd1);
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (done) dpos.push_back(k);
      if (k == 99) start = 1'b0;
    end
    check("held_start_count", 64'(dpos.size()), 64'd3);
    while (dpos.size() < 3) dpos.push_back(-1000);
    check("held_start_first", 64'(dpos[0]), 64'd32);
    check("held_start_period1", 64'(dpos[1] - dpos[0]), 64'd34);
    check("held_start_period2", 64'(dpos[2] - dpos[1]), 64'd34);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
